microsequencer: RTL and testbench
=================================

# microsequencer

Next-state address generator for the microprogrammed control unit. Each cycle it takes the feedback fields latched in the control register (`NS_Ctrl`, `CR_Addr`, `INV_Ctrl`, `COND_Sel`) plus datapath status, and produces the 9-bit microstore address for the next state. It holds the current-state register and a 4-entry microsubroutine return stack. It sits between the control register outputs and the microstore address input, closing the control loop.

## Interface
- `RESET_ADDR`, default 9'd0: state entered on reset and on stack underflow.
- `TRAP_ADDR`, default 9'd480: state entered when a trap is pending at decode.
- `STACK_DEPTH`, default 4: return-stack entries; fixed at 4 in this revision.
- `Clock` input, 1 bit: the single clock; state updates on the rising edge.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `NS_Ctrl` input, 3 bits: next-state selector code from the control register.
- `CR_Addr` input, 9 bits: branch, jump or call target from the control register.
- `INV_Ctrl` input, 1 bit: inverts the selected condition.
- `COND_Sel` input, 2 bits: condition select. 00 = `MOC`, 01 = `Cond`, 10 = `Trap_Req`, 11 = constant 1.
- `MOC` input, 1 bit: memory operation complete.
- `Cond` input, 1 bit: branch condition from the condition tester.
- `Trap_Req` input, 1 bit: a trap is pending.
- `Encoder_Addr` input, 9 bits: decode-target state from the instruction encoder.
- `Next_State` output, 9 bits: combinational next microstore address.
- `Current_State` output, 9 bits: registered current state.
- `Stack_Err` output, 1 bit: sticky flag for stack overflow or underflow.
- `Stack_Level` output, 3 bits: number of occupied stack entries (0–4).

## Operation
- Selected condition: `C = mux(COND_Sel) ^ INV_Ctrl`.
- Increment: `Inc = Current_State + 1`, computed modulo 512, so 511 wraps to 0.
- `NS_Ctrl` 000, increment: `Next_State = Inc`.
- `NS_Ctrl` 001, jump: `Next_State = CR_Addr`.
- `NS_Ctrl` 010, decode: `Next_State = Trap_Req ? TRAP_ADDR : Encoder_Addr`.
- `NS_Ctrl` 011, conditional branch: `C ? CR_Addr : Inc`.
- `NS_Ctrl` 100, wait: `C ? Inc : Current_State`. With `COND_Sel`=00 and `INV_Ctrl`=0 this stalls until `MOC`=1.
- `NS_Ctrl` 101, call: push `Inc`, then `Next_State = CR_Addr`.
  - If the stack is full, the push is dropped, `Stack_Err` is set, and the jump still occurs.
- `NS_Ctrl` 110, return: `Next_State` = top of stack, then pop.
  - If the stack is empty, `Next_State = RESET_ADDR`, `Stack_Err` is set, and `Stack_Level` stays 0.
- `NS_Ctrl` 111, conditional call: behaves as 101 when `C`=1, otherwise as 000 with no push.
- `Stack_Err` is cleared only by `Reset`.
- The stack is LIFO. A push writes `entry[level]` and sets `level + 1`. A pop reads `entry[level - 1]`.

## Timing
- Reset (asynchronous, high):
  - `Current_State` = `RESET_ADDR`, `Stack_Level` = 0, `Stack_Err` = 0.
  - Stack contents are don't-care.
  - `Next_State` is forced to `RESET_ADDR` while `Reset` is high.
- Rising edge of `Clock`: `Current_State <= Next_State`, and the stack pointer and stack entries update per the rules above.
- `Next_State` is purely combinational from `Current_State`, the stack top and the inputs, with zero-cycle latency. It must settle within half a cycle, because the microstore output is latched by the control register on the falling edge.
- Wait states hold `Current_State` for every cycle in which `C`=0. Advancing occurs on the first rising edge that samples `C`=1.
- `Reset` asserted mid-call or mid-wait discards stack contents. The first post-reset `Next_State` is computed from `RESET_ADDR`.
- The pointer change is a single update per edge. No other simultaneous push and pop case exists, since only one `NS_Ctrl` code applies per cycle.

## Test plan
- Reset and increment: assert `Reset`, release, apply `NS_Ctrl`=000 for 3 cycles. `Current_State` must read 0, 1, 2, 3. Preloading 511 and incrementing must give 0.
- Decode and trap:
  - `NS_Ctrl`=010, `Encoder_Addr`=0x0A5, `Trap_Req`=0 → `Next_State`=0x0A5.
  - Same with `Trap_Req`=1 → 480.
- Conditional branch: `NS_Ctrl`=011, `COND_Sel`=01, `CR_Addr`=0x100, `Current_State`=0x020.
  - `Cond`=1, `INV_Ctrl`=0 → 0x100.
  - `Cond`=1, `INV_Ctrl`=1 → 0x021.
- `MOC` wait: `NS_Ctrl`=100, `COND_Sel`=00, `MOC` held low for 3 cycles then high. `Current_State` must hold for 3 edges, then advance by 1 on the next edge.
- Nested call and return:
  - Five calls from states 10, 20, 30, 40, 50 to targets 20, 30, 40, 50, 60. The fifth call sets `Stack_Err`=1, `Stack_Level` stays 4, and the state reaches 60.
  - Four returns then give 41, 31, 21, 11.
  - A fifth return gives `RESET_ADDR`.
- Reset mid-operation: perform 2 calls, assert `Reset` asynchronously between edges. Outputs clear immediately: `Stack_Level`=0, `Current_State`=0, `Stack_Err`=0.

Source files
------------

// File: rtl/microsequencer_if.sv
// Control-register feedback fields, datapath status and sequencer outputs
// exchanged between the control register side and the microsequencer.
interface microsequencer_if;
   logic [2:0] NS_Ctrl;
   logic [8:0] CR_Addr;
   logic       INV_Ctrl;
   logic [1:0] COND_Sel;
   logic       MOC;
   logic       Cond;
   logic       Trap_Req;
   logic [8:0] Encoder_Addr;
   logic [8:0] Next_State;
   logic [8:0] Current_State;
   logic       Stack_Err;
   logic [2:0] Stack_Level;

   modport master (
      output NS_Ctrl, CR_Addr, INV_Ctrl, COND_Sel, MOC, Cond, Trap_Req, Encoder_Addr,
      input  Next_State, Current_State, Stack_Err, Stack_Level
   );

   modport slave (
      input  NS_Ctrl, CR_Addr, INV_Ctrl, COND_Sel, MOC, Cond, Trap_Req, Encoder_Addr,
      output Next_State, Current_State, Stack_Err, Stack_Level
   );
endinterface

// File: rtl/microsequencer.sv
// Next microstore address generator: current-state register, condition
// select, and a small LIFO return stack for microsubroutine calls.
module microsequencer #(
   parameter logic [8:0]  RESET_ADDR  = 9'd0,
   parameter logic [8:0]  TRAP_ADDR   = 9'd480,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   microsequencer_if.slave  bus
);

   localparam int unsigned IDX_W      = $clog2(STACK_DEPTH);
   localparam logic [2:0]  FULL_LEVEL = 3'(STACK_DEPTH);

   logic [8:0]       state_q, state_d;
   logic [2:0]       level_q, level_d;
   logic             err_q, err_d;
   logic [8:0]       stack_q [STACK_DEPTH];

   logic             cond_s;
   logic [8:0]       inc_s;
   logic [8:0]       top_s;
   logic             push_s, pop_s, stack_we_s;
   logic             full_s, empty_s;
   logic [IDX_W-1:0] wr_idx_s, rd_idx_s;

   assign inc_s    = state_q + 9'd1;
   assign full_s   = (level_q == FULL_LEVEL);
   assign empty_s  = (level_q == 3'd0);
   assign wr_idx_s = level_q[IDX_W-1:0];
   assign rd_idx_s = IDX_W'(level_q - 3'd1);
   assign top_s    = stack_q[rd_idx_s];

   // Next-state: address selection plus stack pointer and error flag update
   always_comb begin
      state_d    = inc_s;
      push_s     = 1'b0;
      pop_s      = 1'b0;
      level_d    = level_q;
      err_d      = err_q;
      stack_we_s = 1'b0;

      case (bus.COND_Sel)
         2'b00:   cond_s = bus.MOC;
         2'b01:   cond_s = bus.Cond;
         2'b10:   cond_s = bus.Trap_Req;
         default: cond_s = 1'b1;
      endcase
      cond_s = cond_s ^ bus.INV_Ctrl;

      case (bus.NS_Ctrl)
         3'b000:  state_d = inc_s;
         3'b001:  state_d = bus.CR_Addr;
         3'b010:  state_d = bus.Trap_Req ? TRAP_ADDR : bus.Encoder_Addr;
         3'b011:  state_d = cond_s ? bus.CR_Addr : inc_s;
         3'b100:  state_d = cond_s ? inc_s : state_q;
         3'b101: begin
            push_s  = 1'b1;
            state_d = bus.CR_Addr;
         end
         3'b110: begin
            pop_s   = 1'b1;
            state_d = empty_s ? RESET_ADDR : top_s;
         end
         3'b111: begin
            push_s  = cond_s;
            state_d = cond_s ? bus.CR_Addr : inc_s;
         end
         default: state_d = inc_s;
      endcase

      // Reset must present RESET_ADDR to the microstore and freeze the stack
      if (Reset) begin
         state_d = RESET_ADDR;
         push_s  = 1'b0;
         pop_s   = 1'b0;
      end else begin
         state_d = state_d;
      end

      if (push_s) begin
         if (full_s) begin
            err_d = 1'b1;
         end else begin
            level_d    = level_q + 3'd1;
            stack_we_s = 1'b1;
         end
      end else if (pop_s) begin
         if (empty_s) begin
            err_d = 1'b1;
         end else begin
            level_d = level_q - 3'd1;
         end
      end else begin
         level_d = level_q;
      end
   end

   // State register, stack pointer and sticky error flag
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= RESET_ADDR;
         level_q <= 3'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         err_q   <= err_d;
      end
   end

   // Stack storage; contents are meaningless after reset so no reset is needed
   always_ff @(posedge Clock) begin
      if (stack_we_s) begin
         stack_q[wr_idx_s] <= inc_s;
      end
   end

   // Output drive
   always_comb begin
      bus.Next_State    = state_d;
      bus.Current_State = state_q;
      bus.Stack_Err     = err_q;
      bus.Stack_Level   = level_q;
   end

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for the microsequencer: directed test-plan sequences
// followed by randomized control words, checked against a queue-based model.
module tb_microsequencer;

   logic Clock = 1'b0;
   logic Reset = 1'b0;

   microsequencer_if bus ();

   microsequencer #(
      .RESET_ADDR  (9'd0),
      .TRAP_ADDR   (9'd480),
      .STACK_DEPTH (4)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int ns;
      int cs;
      int lvl;
      int err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   int   m_cs  = 0;
   int   m_stk[$];
   int   m_err = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cs  = 0;
      m_stk.delete();
      m_err = 0;
   endtask

   // Inputs that hold the state (wait on MOC with MOC low)
   task automatic park();
      bus.NS_Ctrl      = 3'b100;
      bus.CR_Addr      = 9'd0;
      bus.INV_Ctrl     = 1'b0;
      bus.COND_Sel     = 2'b00;
      bus.MOC          = 1'b0;
      bus.Cond         = 1'b0;
      bus.Trap_Req     = 1'b0;
      bus.Encoder_Addr = 9'd0;
   endtask

   // Drive one control word just after a rising edge and queue the model's view
   task automatic step(input int nsc, input int cr, input int inv, input int csel,
                       input int moc, input int cnd, input int trp, input int enc);
      exp_t e;
      int   c;
      int   inc;
      int   ns;
      @(posedge Clock);
      #1;
      bus.NS_Ctrl      = 3'(nsc);
      bus.CR_Addr      = 9'(cr);
      bus.INV_Ctrl     = 1'(inv);
      bus.COND_Sel     = 2'(csel);
      bus.MOC          = 1'(moc);
      bus.Cond         = 1'(cnd);
      bus.Trap_Req     = 1'(trp);
      bus.Encoder_Addr = 9'(enc);

      e.cs  = m_cs;
      e.lvl = m_stk.size();
      e.err = m_err;

      case (csel)
         0:       c = moc;
         1:       c = cnd;
         2:       c = trp;
         default: c = 1;
      endcase
      c   = c ^ inv;
      inc = (m_cs + 1) % 512;

      if (nsc == 7) nsc = c ? 5 : 0;
      case (nsc)
         0: ns = inc;
         1: ns = cr;
         2: ns = trp ? 480 : enc;
         3: ns = c ? cr : inc;
         4: ns = c ? inc : m_cs;
         5: begin
            if (m_stk.size() == 4) m_err = 1;
            else m_stk.push_back(inc);
            ns = cr;
         end
         default: begin
            if (m_stk.size() == 0) begin
               m_err = 1;
               ns    = 0;
            end else begin
               ns = m_stk.pop_back();
            end
         end
      endcase

      e.ns = ns;
      sb.push_back(e);
      m_cs = ns;
   endtask

   task automatic go(input int nsc, input int cr);
      step(nsc, cr, 0, 3, 0, 0, 0, 0);
   endtask

   task automatic chk_ns(input string name, input int exp);
      #1;
      check(name, int'(bus.Next_State), exp);
   endtask

   // Monitor: pops one expectation per cycle, mid-cycle, once settled
   initial begin
      exp_t e;
      forever begin
         @(negedge Clock);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_next_state", int'(bus.Next_State), e.ns);
            check("sb_current_state", int'(bus.Current_State), e.cs);
            check("sb_stack_level", int'(bus.Stack_Level), e.lvl);
            check("sb_stack_err", int'(bus.Stack_Err), e.err);
         end
      end
   end

   initial begin
      park();
      #1 Reset = 1'b1;
      #2;
      check("rst_current_state", int'(bus.Current_State), 0);
      check("rst_stack_level", int'(bus.Stack_Level), 0);
      check("rst_stack_err", int'(bus.Stack_Err), 0);
      check("rst_next_state", int'(bus.Next_State), 0);
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      model_reset();

      // Increment from reset and wrap at 511
      go(0, 0); go(0, 0); go(0, 0);
      go(1, 511);
      #1 check("inc_three", int'(bus.Current_State), 3);
      go(0, 0);
      chk_ns("inc_wrap", 0);

      // Decode with and without a pending trap
      step(2, 0, 0, 3, 0, 0, 0, 9'h0A5);
      chk_ns("decode", 9'h0A5);
      step(2, 0, 0, 3, 0, 0, 1, 9'h0A5);
      chk_ns("decode_trap", 480);

      // Conditional branch, true and inverted
      go(1, 9'h020);
      step(3, 9'h100, 0, 1, 0, 1, 0, 0);
      #1 check("br_from", int'(bus.Current_State), 9'h020);
      chk_ns("br_taken", 9'h100);
      go(1, 9'h020);
      step(3, 9'h100, 1, 1, 0, 1, 0, 0);
      chk_ns("br_inverted", 9'h021);

      // Wait on MOC: three stalled edges, then advance
      for (int i = 0; i < 3; i++) begin
         step(4, 0, 0, 0, 0, 0, 0, 0);
         chk_ns("wait_hold", 9'h021);
      end
      step(4, 0, 0, 0, 1, 0, 0, 0);
      chk_ns("wait_go", 9'h022);
      go(1, 10);
      #1 check("wait_advanced", int'(bus.Current_State), 9'h022);

      // Nested calls with overflow, then returns with underflow
      go(5, 20); go(5, 30); go(5, 40); go(5, 50);
      go(5, 60);
      #1 check("calls_level", int'(bus.Stack_Level), 4);
      check("calls_no_err", int'(bus.Stack_Err), 0);
      go(6, 0);
      #1 check("ovf_state", int'(bus.Current_State), 60);
      check("ovf_level", int'(bus.Stack_Level), 4);
      check("ovf_err", int'(bus.Stack_Err), 1);
      chk_ns("ret1", 41);
      go(6, 0); chk_ns("ret2", 31);
      go(6, 0); chk_ns("ret3", 21);
      go(6, 0); chk_ns("ret4", 11);
      go(6, 0); chk_ns("ret_underflow", 0);
      go(5, 100);
      #1 check("udf_level", int'(bus.Stack_Level), 0);
      check("udf_err_sticky", int'(bus.Stack_Err), 1);
      go(5, 200);

      // Asynchronous reset between edges after two calls
      @(posedge Clock);
      #3;
      check("pre_rst_level", int'(bus.Stack_Level), 2);
      check("pre_rst_state", int'(bus.Current_State), 200);
      park();
      Reset = 1'b1;
      #1;
      check("mid_rst_state", int'(bus.Current_State), 0);
      check("mid_rst_level", int'(bus.Stack_Level), 0);
      check("mid_rst_err", int'(bus.Stack_Err), 0);
      check("mid_rst_ns", int'(bus.Next_State), 0);
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      model_reset();
      go(0, 0);
      chk_ns("post_rst_inc", 1);

      // Randomized control words
      for (int i = 0; i < 400; i++) begin
         step(int'($urandom_range(0, 7)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 511)));
      end

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge Clock);
      #1;
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
